mask_centroid: RTL and testbench

Streaming centroid stage that sits directly downstream of `morph_open`. It consumes the cleaned binary mask plus its `de`/`h_sync`/`v_sync` timing. Per frame it accumulates the foreground pixel count and the sums of the foreground x and y coordinates, then divides them at frame end with two sequential dividers. The video is passed on with a one-cycle delay, and a red crosshair is drawn at the centroid computed from the previous frame.

---
 rtl/centroid_pkg.sv | 14 +
 rtl/mask_centroid_if.sv | 22 ++
 rtl/mask_centroid_divider.sv | 45 ++++
 rtl/mask_centroid.sv | 125 ++++++++++++
 tb/tb_mask_centroid.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/centroid_pkg.sv
// centroid_pkg: widths, FSM states and overlay colour shared by the centroid stage.
package centroid_pkg;
  typedef enum logic [1:0] {IDLE, DIV, DONE, EMPTY} state_t;
  localparam logic [23:0] OVL_RGB = 24'hFF0000;
  function automatic int coord_w(input int n);
    return $clog2(n);
  endfunction
  function automatic int cnt_w(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction
  function automatic int sum_w(input int w, input int h);
    return cnt_w(w, h) + ((coord_w(w) > coord_w(h)) ? coord_w(w) : coord_w(h));
  endfunction
endpackage

// File: rtl/mask_centroid_if.sv
// mask_centroid_if: mask video in, delayed/overlaid video and centroid results out.
interface mask_centroid_if #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
);
  logic [23:0] mask_in;
  logic de_in, h_sync_in, v_sync_in;
  logic de_out, h_sync_out, v_sync_out;
  logic [23:0] pixel_out;
  logic [centroid_pkg::coord_w(IMG_W)-1:0] x_c;
  logic [centroid_pkg::coord_w(IMG_H)-1:0] y_c;
  logic [centroid_pkg::cnt_w(IMG_W, IMG_H)-1:0] obj_cnt;
  logic empty, c_valid;
  modport master (
    output mask_in, de_in, h_sync_in, v_sync_in,
    input de_out, h_sync_out, v_sync_out, pixel_out, x_c, y_c, obj_cnt, empty, c_valid
  );
  modport slave (
    input mask_in, de_in, h_sync_in, v_sync_in,
    output de_out, h_sync_out, v_sync_out, pixel_out, x_c, y_c, obj_cnt, empty, c_valid
  );
endinterface

// File: rtl/mask_centroid_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, W cycles after start.
module seq_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int C_W = $clog2(W + 1);
  logic [W-1:0] r_rem, r_quo, r_div;
  logic [C_W-1:0] r_cnt;
  logic r_done;
  logic [W:0] w_shift, w_diff;
  // remainder always stays below the divisor, so bit W of the difference is the borrow
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem <= '0;
        r_quo <= dividend;
        r_div <= divisor;
        r_cnt <= C_W'(W);
      end else if (r_cnt != '0) begin
        r_rem  <= w_diff[W] ? w_shift[W-1:0] : w_diff[W-1:0];
        r_quo  <= {r_quo[W-2:0], ~w_diff[W]};
        r_cnt  <= r_cnt - 1'b1;
        r_done <= r_cnt == C_W'(1);
      end
    end
  end
  assign quotient = r_quo;
  assign done     = r_done;
endmodule

// File: rtl/mask_centroid.sv
// mask_centroid: per-frame foreground centroid of a binary mask, with crosshair
// overlay of the previous frame's centroid on the 1-cycle delayed video.
module mask_centroid
  import centroid_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic clk,
  input logic rst_n,
  mask_centroid_if.slave bus
);
  localparam int X_W   = coord_w(IMG_W);
  localparam int Y_W   = coord_w(IMG_H);
  localparam int CNT_W = cnt_w(IMG_W, IMG_H);
  localparam int SUM_W = sum_w(IMG_W, IMG_H);
  state_t r_state, w_state_n;
  logic r_de, r_hs, r_vs, r_empty, r_cv;
  logic [23:0] r_pix;
  logic [X_W-1:0] r_x, r_x_c;
  logic [Y_W-1:0] r_y, r_y_c;
  logic [CNT_W-1:0] r_cnt, r_cnt_snap, r_obj;
  logic [SUM_W-1:0] r_sx, r_sy, w_qx, w_qy;
  logic w_frame_end, w_start, w_done_x, w_done_y, w_hit, w_load_div, w_load_emp, w_unused;
  assign w_frame_end = bus.v_sync_in & ~r_vs;
  assign w_start     = w_frame_end & (r_state == IDLE) & (r_cnt != '0);
  assign w_hit       = bus.de_in & ~r_empty & ((r_x == r_x_c) | (r_y == r_y_c));
  assign w_load_div  = (r_state == DIV) & w_done_x;
  assign w_load_emp  = r_state == EMPTY;
  assign w_unused    = ^{w_qx[SUM_W-1:X_W], w_qy[SUM_W-1:Y_W], w_done_y};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_pix <= '0;
    end else begin
      r_de  <= bus.de_in;
      r_hs  <= bus.h_sync_in;
      r_vs  <= bus.v_sync_in;
      r_pix <= w_hit ? OVL_RGB : bus.mask_in;
    end
  end
  // r_de doubles as the previous de_in for the end-of-line detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_frame_end) begin
      r_x <= '0;
      r_y <= '0;
    end else if (bus.de_in) begin
      r_x <= r_x + 1'b1;
    end else if (r_de) begin
      r_x <= '0;
      r_y <= r_y + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
    end else if (w_frame_end) begin
      r_cnt <= '0;
      r_sx  <= '0;
      r_sy  <= '0;
    end else if (bus.de_in & bus.mask_in[0]) begin
      r_cnt <= r_cnt + 1'b1;
      r_sx  <= r_sx + SUM_W'(r_x);
      r_sy  <= r_sy + SUM_W'(r_y);
    end
  end
  seq_divider #(.W(SUM_W)) u_div_x (
    .clk(clk), .rst_n(rst_n), .start(w_start), .dividend(r_sx),
    .divisor(SUM_W'(r_cnt)), .quotient(w_qx), .done(w_done_x)
  );
  seq_divider #(.W(SUM_W)) u_div_y (
    .clk(clk), .rst_n(rst_n), .start(w_start), .dividend(r_sy),
    .divisor(SUM_W'(r_cnt)), .quotient(w_qy), .done(w_done_y)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_n;
  end
  // frame ends seen outside IDLE are dropped; the accumulators still clear
  always_comb begin
    w_state_n = r_state;
    w_state_n = (r_state == IDLE) ? (w_frame_end ? ((r_cnt == '0) ? EMPTY : DIV) : IDLE)
              : (r_state == DIV)  ? (w_done_x ? DONE : DIV)
              : IDLE;
  end
  // results register on the DIV->DONE step and in EMPTY so c_valid lands SUM_W+2 / 2 cycles out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_snap <= '0;
      r_x_c      <= '0;
      r_y_c      <= '0;
      r_obj      <= '0;
      r_empty    <= 1'b1;
      r_cv       <= 1'b0;
    end else begin
      r_cv <= w_load_div | w_load_emp;
      if (w_start) r_cnt_snap <= r_cnt;
      if (w_load_div) begin
        r_x_c   <= w_qx[X_W-1:0];
        r_y_c   <= w_qy[Y_W-1:0];
        r_obj   <= r_cnt_snap;
        r_empty <= 1'b0;
      end else if (w_load_emp) begin
        r_obj   <= '0;
        r_empty <= 1'b1;
      end
    end
  end
  assign bus.de_out     = r_de;
  assign bus.h_sync_out = r_hs;
  assign bus.v_sync_out = r_vs;
  assign bus.pixel_out  = r_pix;
  assign bus.x_c        = r_x_c;
  assign bus.y_c        = r_y_c;
  assign bus.obj_cnt    = r_obj;
  assign bus.empty      = r_empty;
  assign bus.c_valid    = r_cv;
endmodule

// File: tb/tb_mask_centroid.sv
// tb_mask_centroid: scoreboard bench; frames from arrays, expected video and
// centroid results from a frame-level arithmetic model.
module tb_mask_centroid;
  import centroid_pkg::*;
  localparam int W = 8;
  localparam int H = 8;
  localparam int SW = sum_w(W, H);
  typedef struct {int x; int y; int cnt; bit emp; int lat; int t;} res_t;
  typedef struct {bit de; bit hs; bit vs; logic [23:0] pix;} vid_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  res_t rq[$];
  vid_t vq[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit fr[H][W];
  int hx = 0, hy = 0;
  bit hemp = 1'b1;
  bit vchk = 1'b0;
  mask_centroid_if #(.IMG_W(W), .IMG_H(H)) bus ();
  mask_centroid #(.IMG_W(W), .IMG_H(H)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic drive(input bit de, input bit hs, input bit vs, input bit fg, input int x, input int y);
    @(negedge clk);
    bus.de_in = de;
    bus.h_sync_in = hs;
    bus.v_sync_in = vs;
    bus.mask_in = fg ? 24'hFFFFFF : 24'h000000;
    if (vchk) vq.push_back('{de, hs, vs, (de && !hemp && (x == hx || y == hy)) ? OVL_RGB : bus.mask_in});
  endtask
  task automatic do_reset();
    vchk = 1'b0;
    vq.delete();
    rst_n = 1'b0;
    #1;
    chk("rst_x_c", 64'(bus.x_c), 0);
    chk("rst_y_c", 64'(bus.y_c), 0);
    chk("rst_obj_cnt", 64'(bus.obj_cnt), 0);
    chk("rst_empty", 64'(bus.empty), 1);
    chk("rst_c_valid", 64'(bus.c_valid), 0);
    chk("rst_video", 64'({bus.de_out, bus.h_sync_out, bus.v_sync_out, bus.pixel_out}), 0);
    rq.delete();
    hx = 0;
    hy = 0;
    hemp = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vchk = 1'b1;
  endtask
  task automatic send_frame(input bit abort);
    int c, sx, sy;
    res_t e;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) drive(1, 0, 0, fr[y][x], x, y);
      for (int k = 0; k < 4; k++) drive(0, k == 1 || k == 2, 0, 0, 0, 0);
    end
    c = 0;
    sx = 0;
    sy = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (fr[y][x]) begin
          c++;
          sx += x;
          sy += y;
        end
    drive(0, 0, 1, 0, 0, 0);
    e.t = cyc;
    e.cnt = c;
    e.emp = (c == 0);
    e.lat = (c == 0) ? 2 : SW + 2;
    e.x = (c == 0) ? hx : sx / c;
    e.y = (c == 0) ? hy : sy / c;
    rq.push_back(e);
    hx = e.x;
    hy = e.y;
    hemp = e.emp;
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      if (abort && k == 3) do_reset();
    end
  endtask
  task automatic fill(input int x0, input int x1, input int y0, input int y1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fr[y][x] = (x >= x0 && x <= x1 && y >= y0 && y <= y1);
  endtask
  task automatic fill_rand();
    int d;
    d = $urandom_range(0, 100);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) fr[y][x] = ($urandom_range(0, 99) < d);
  endtask
  always begin
    vid_t v;
    res_t r;
    @(posedge clk);
    #1;
    if (vq.size() > 0) begin
      v = vq.pop_front();
      chk("video", 64'({bus.de_out, bus.h_sync_out, bus.v_sync_out, bus.pixel_out}),
          64'({v.de, v.hs, v.vs, v.pix}));
    end
    if (bus.c_valid === 1'b1) begin
      if (rq.size() == 0) begin
        chk("c_valid_unexpected", 1, 0);
      end else begin
        r = rq.pop_front();
        chk("x_c", 64'(bus.x_c), 64'(r.x));
        chk("y_c", 64'(bus.y_c), 64'(r.y));
        chk("obj_cnt", 64'(bus.obj_cnt), 64'(r.cnt));
        chk("empty", 64'(bus.empty), 64'(r.emp));
        chk("latency", 64'(cyc - r.t), 64'(r.lat));
      end
    end
  end
  initial begin
    bus.de_in = 1'b0;
    bus.h_sync_in = 1'b0;
    bus.v_sync_in = 1'b0;
    bus.mask_in = '0;
    repeat (3) @(negedge clk);
    chk("init_empty", 64'(bus.empty), 1);
    chk("init_c_valid", 64'(bus.c_valid), 0);
    chk("init_x_c", 64'(bus.x_c), 0);
    chk("init_obj_cnt", 64'(bus.obj_cnt), 0);
    rst_n = 1'b1;
    vchk = 1'b1;
    fill(3, 3, 5, 5);
    send_frame(0);
    fill(2, 3, 4, 5);
    send_frame(0);
    fill(1, 0, 0, 0);
    send_frame(0);
    send_frame(0);
    fill(0, W - 1, 0, H - 1);
    send_frame(0);
    fill_rand();
    fr[2][6] = 1'b1;
    send_frame(1);
    fill(3, 3, 5, 5);
    send_frame(0);
    for (int f = 0; f < 6; f++) begin
      fill_rand();
      send_frame(0);
    end
    repeat (20) drive(0, 0, 0, 0, 0, 0);
    chk("results_pending", 64'(rq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
